commit_retire_unit: RTL and testbench
=====================================

Name: commit_retire_unit

Overview:
- In-order retirement engine for the out-of-order MIPS core. Each cycle it scans the commit window starting at the active-list head and decides how many consecutive instructions retire.
- Drives the commit output interface consumed by the state-update logic: commit_valid, last_valid_commit_idx, and per-slot load/store/branch flags.
- Owns the head, load, store and branch commit pointers.
- Drains each retired store to the D-cache through a valid/ready write handshake.

Parameters:
- ACTIVE_LIST_SIZE, 64: active-list entries (power of 2); AL_IDX = log2 = 6.
- COMMIT_WINDOW_SIZE, 4: maximum retirements per cycle; CW_IDX = 2.
- LOAD_STORE_SIZE, 16: load/store queue entries (power of 2); LS_IDX = 4.
- BRANCH_NUM, 8: branch-state entries (power of 2); BR_IDX = 3.

Ports:
- clk in 1: single clock.
- rst in 1: reset, synchronous, active-high.
- branch_miss in 1: misprediction recovery this cycle.
- ready_to_commit in ACTIVE_LIST_SIZE: entry has completed.
- entry_available_bit in ACTIVE_LIST_SIZE: 1 = slot empty.
- is_load in ACTIVE_LIST_SIZE: entry is a load.
- is_store in ACTIVE_LIST_SIZE: entry is a store.
- is_branch in ACTIVE_LIST_SIZE: entry is a branch.
- commit_valid out 1: at least one instruction retires this cycle.
- last_valid_commit_idx out CW_IDX: window slot of the youngest retiring instruction.
- load_valid out COMMIT_WINDOW_SIZE: slot i retires a load.
- store_valid out COMMIT_WINDOW_SIZE: slot i retires a store.
- branch_valid out COMMIT_WINDOW_SIZE: slot i retires a branch.
- oldest_inst_pointer out AL_IDX: active-list head.
- load_commit_pointer out LS_IDX: load queue commit pointer.
- store_commit_pointer out LS_IDX: store queue commit pointer.
- branch_read_pointer out BR_IDX: branch-state read pointer.
- st_req_valid out 1: store write request to the D-cache.
- st_req_index out LS_IDX: store-queue entry being written.
- st_req_ready in 1: D-cache accepts the write.
- retired_count out 32: performance counter of retired instructions.

Behaviour:
- Reset (rst=1 at posedge): all four pointers = 0; drain FSM = IDLE; st_req_valid = 0; st_req_index = 0; retired_count = 0. Commit outputs are forced to 0 while rst is high.
- Window scan is combinational from the current registers and inputs:
  - Slot i examines idx = (oldest_inst_pointer + i) mod ACTIVE_LIST_SIZE.
  - Slot i retires only if:
    - slot i-1 retired (slot 0 is exempt);
    - entry_available_bit[idx] = 0;
    - ready_to_commit[idx] = 1;
    - it is not a store, or it is the first store this cycle and the drain FSM is IDLE.
  - The first failing slot ends the window; no younger slot retires.
- Output encoding:
  - count = number of retiring slots.
  - commit_valid = (count > 0).
  - last_valid_commit_idx = count-1, or 0 when count = 0.
  - load_valid, store_valid and branch_valid are the per-slot type bits masked by retirement.
- The window never wraps onto itself; COMMIT_WINDOW_SIZE < ACTIVE_LIST_SIZE.
- branch_miss=1 forces commit_valid=0 and all slot flags to 0; pointers hold for that cycle. Retirement resumes the next cycle.
- Pointer update at posedge (all arithmetic modulo size, natural wrap):
  - oldest_inst_pointer += count.
  - load_commit_pointer += popcount(load_valid).
  - store_commit_pointer += popcount(store_valid).
  - branch_read_pointer += popcount(branch_valid).
  - retired_count += count, wrapping at 2^32.
- Drain FSM, two states:
  - IDLE: if a store retires this cycle, latch st_req_index = current store_commit_pointer and go to WRITE next cycle.
  - WRITE: st_req_valid=1. When st_req_ready=1, return to IDLE. While waiting, st_req_index is held stable.
  - One store latency: retire at cycle T, request at T+1, earliest next store retirement in the cycle after acceptance.
- The drain FSM ignores branch_miss: a retired store is architectural and always completes.
- Reset while in WRITE abandons the request immediately; the next cycle shows st_req_valid=0.
- An empty active list (head slot available) gives commit_valid=0, and the pointers are stable.

Decomposition:
- Shared core package holds:
  - the size macros ACTIVE_LIST_SIZE, COMMIT_WINDOW_SIZE, LOAD_STORE_SIZE, BRANCH_NUM and their _INDEX widths;
  - the drain state enum, drain_state_t {IDLE, WRITE}.
- Commit output signals are grouped under the existing commit_output_ifc modport.
- One natural sub-module: store_drain_fsm, containing the FSM, the index latch and the handshake.

Test Plan:
- Reset, then head=0 with slots 0..3 all ready, entry 1 a load, entry 2 a branch, no stores -> commit_valid=1, last_valid_commit_idx=3, load_valid=0010, branch_valid=0100; next cycle oldest=4, load_commit_pointer=1, branch_read_pointer=1, retired_count=4.
- Entries 0 and 1 ready, entry 2 not ready, entry 3 ready -> last_valid_commit_idx=1; slot 3 is not retired; oldest=2.
- Entries 0..3 all ready, stores at entries 1 and 2, st_req_ready held 0 for 3 cycles -> only slots 0..1 retire; the next cycle raises st_req_valid with index 0; entry 2 is blocked until the cycle after st_req_ready=1.
- Head=62, entries 62, 63, 0, 1 all ready -> 4 retire; oldest wraps to 2. store_commit_pointer at 15 with one store retiring -> wraps to 0.
- branch_miss=1 while 3 entries are ready -> commit_valid=0 and pointers unchanged. An in-flight store write still completes on st_req_ready.
- rst asserted in WRITE with st_req_ready=0 -> next cycle st_req_valid=0, pointers=0, retired_count=0.

Source files
------------

// File: rtl/commit_retire_unit_pkg.sv
// commit_retire_unit_pkg: shared sizes, drain state and helper for the retirement engine
package commit_retire_unit_pkg;
  localparam int ACTIVE_LIST_SIZE    = 64;
  localparam int ACTIVE_LIST_INDEX   = $clog2(ACTIVE_LIST_SIZE);
  localparam int COMMIT_WINDOW_SIZE  = 4;
  localparam int COMMIT_WINDOW_INDEX = $clog2(COMMIT_WINDOW_SIZE);
  localparam int LOAD_STORE_SIZE     = 16;
  localparam int LOAD_STORE_INDEX    = $clog2(LOAD_STORE_SIZE);
  localparam int BRANCH_NUM          = 8;
  localparam int BRANCH_INDEX        = $clog2(BRANCH_NUM);
  typedef enum logic {IDLE, WRITE} drain_state_t;
  function automatic logic [COMMIT_WINDOW_INDEX:0] popcount(input logic [COMMIT_WINDOW_SIZE-1:0] v);
    logic [COMMIT_WINDOW_INDEX:0] c;
    c = '0;
    for (int i = 0; i < COMMIT_WINDOW_SIZE; i++) c = c + {{COMMIT_WINDOW_INDEX{1'b0}}, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/store_drain_fsm.sv
// store_drain_fsm: issues one D-cache write per retired store via a valid/ready handshake
module store_drain_fsm
  import commit_retire_unit_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_store_retire,
  input  logic [LOAD_STORE_INDEX-1:0] i_store_ptr,
  input  logic                        i_st_req_ready,
  output logic                        o_idle,
  output logic                        o_st_req_valid,
  output logic [LOAD_STORE_INDEX-1:0] o_st_req_index
);
  drain_state_t r_state, w_next;
  logic [LOAD_STORE_INDEX-1:0] r_index;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_store_retire) r_index <= i_store_ptr;
    end
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (i_store_retire ? WRITE : IDLE) : (i_st_req_ready ? IDLE : WRITE);
  end
  assign o_idle         = r_state == IDLE;
  assign o_st_req_valid = r_state == WRITE;
  assign o_st_req_index = r_index;
endmodule

// File: rtl/commit_retire_unit.sv
// commit_retire_unit: in-order retirement of up to COMMIT_WINDOW_SIZE instructions per cycle
module commit_retire_unit
  import commit_retire_unit_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           branch_miss,
  input  logic [ACTIVE_LIST_SIZE-1:0]    ready_to_commit,
  input  logic [ACTIVE_LIST_SIZE-1:0]    entry_available_bit,
  input  logic [ACTIVE_LIST_SIZE-1:0]    is_load,
  input  logic [ACTIVE_LIST_SIZE-1:0]    is_store,
  input  logic [ACTIVE_LIST_SIZE-1:0]    is_branch,
  output logic                           commit_valid,
  output logic [COMMIT_WINDOW_INDEX-1:0] last_valid_commit_idx,
  output logic [COMMIT_WINDOW_SIZE-1:0]  load_valid,
  output logic [COMMIT_WINDOW_SIZE-1:0]  store_valid,
  output logic [COMMIT_WINDOW_SIZE-1:0]  branch_valid,
  output logic [ACTIVE_LIST_INDEX-1:0]   oldest_inst_pointer,
  output logic [LOAD_STORE_INDEX-1:0]    load_commit_pointer,
  output logic [LOAD_STORE_INDEX-1:0]    store_commit_pointer,
  output logic [BRANCH_INDEX-1:0]        branch_read_pointer,
  output logic                           st_req_valid,
  output logic [LOAD_STORE_INDEX-1:0]    st_req_index,
  input  logic                           st_req_ready,
  output logic [31:0]                    retired_count
);
  logic [COMMIT_WINDOW_SIZE-1:0][ACTIVE_LIST_INDEX-1:0] w_idx;
  logic [COMMIT_WINDOW_SIZE-1:0] w_ret;
  logic [COMMIT_WINDOW_INDEX:0]  w_cnt;
  logic                          w_prev, w_seen, w_idle;
  logic [ACTIVE_LIST_INDEX-1:0]  r_oldest;
  logic [LOAD_STORE_INDEX-1:0]   r_ld, r_st;
  logic [BRANCH_INDEX-1:0]       r_br;
  logic [31:0]                   r_cnt;
  for (genvar i = 0; i < COMMIT_WINDOW_SIZE; i++) begin : g_slot
    assign w_idx[i]        = r_oldest + ACTIVE_LIST_INDEX'(i);
    assign load_valid[i]   = w_ret[i] & is_load[w_idx[i]];
    assign store_valid[i]  = w_ret[i] & is_store[w_idx[i]];
    assign branch_valid[i] = w_ret[i] & is_branch[w_idx[i]];
  end
  // Only one store may retire per cycle, and only while the drain engine is free
  always_comb begin
    w_ret  = '0;
    w_seen = 1'b0;
    w_prev = !rst && !branch_miss;
    for (int i = 0; i < COMMIT_WINDOW_SIZE; i++) begin
      w_ret[i] = w_prev && !entry_available_bit[w_idx[i]] && ready_to_commit[w_idx[i]] &&
                 (!is_store[w_idx[i]] || (!w_seen && w_idle));
      w_seen   = w_seen | (w_ret[i] & is_store[w_idx[i]]);
      w_prev   = w_ret[i];
    end
  end
  assign w_cnt                 = popcount(w_ret);
  assign commit_valid          = |w_ret;
  assign last_valid_commit_idx = (w_cnt == '0) ? '0 : COMMIT_WINDOW_INDEX'(w_cnt - 1'b1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oldest <= '0;
      r_ld     <= '0;
      r_st     <= '0;
      r_br     <= '0;
      r_cnt    <= '0;
    end else begin
      r_oldest <= r_oldest + ACTIVE_LIST_INDEX'(w_cnt);
      r_ld     <= r_ld + LOAD_STORE_INDEX'(popcount(load_valid));
      r_st     <= r_st + LOAD_STORE_INDEX'(popcount(store_valid));
      r_br     <= r_br + BRANCH_INDEX'(popcount(branch_valid));
      r_cnt    <= r_cnt + 32'(w_cnt);
    end
  end
  assign oldest_inst_pointer  = r_oldest;
  assign load_commit_pointer  = r_ld;
  assign store_commit_pointer = r_st;
  assign branch_read_pointer  = r_br;
  assign retired_count        = r_cnt;
  store_drain_fsm u_drain (
    .clk            (clk),
    .rst            (rst),
    .i_store_retire (|store_valid),
    .i_store_ptr    (r_st),
    .i_st_req_ready (st_req_ready),
    .o_idle         (w_idle),
    .o_st_req_valid (st_req_valid),
    .o_st_req_index (st_req_index)
  );
endmodule

// File: tb/tb_commit_retire_unit.sv
// tb_commit_retire_unit: scoreboard bench; stimulus queues expected commits and store requests
module tb_commit_retire_unit;
  logic        clk, rst, branch_miss, st_req_ready;
  logic [63:0] rdy, avail, ild, ist, ibr;
  logic        commit_valid, st_req_valid;
  logic [1:0]  last_valid_commit_idx;
  logic [3:0]  load_valid, store_valid, branch_valid;
  logic [5:0]  oldest_inst_pointer;
  logic [3:0]  load_commit_pointer, store_commit_pointer, st_req_index;
  logic [2:0]  branch_read_pointer;
  logic [31:0] retired_count;
  typedef struct {
    logic [1:0]  last;
    logic [3:0]  ld, st, br;
    logic [5:0]  old;
    logic [3:0]  ldp, stp;
    logic [2:0]  brp;
    logic [31:0] cnt;
  } exp_t;
  exp_t       cq[$];
  logic [3:0] sq[$];
  exp_t       m_e;
  logic [3:0] m_idx;
  logic       prev_v;
  int         n_chk = 0, n_fail = 0;
  commit_retire_unit dut (
    .clk(clk), .rst(rst), .branch_miss(branch_miss),
    .ready_to_commit(rdy), .entry_available_bit(avail),
    .is_load(ild), .is_store(ist), .is_branch(ibr),
    .commit_valid(commit_valid), .last_valid_commit_idx(last_valid_commit_idx),
    .load_valid(load_valid), .store_valid(store_valid), .branch_valid(branch_valid),
    .oldest_inst_pointer(oldest_inst_pointer), .load_commit_pointer(load_commit_pointer),
    .store_commit_pointer(store_commit_pointer), .branch_read_pointer(branch_read_pointer),
    .st_req_valid(st_req_valid), .st_req_index(st_req_index), .st_req_ready(st_req_ready),
    .retired_count(retired_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic push(input logic [1:0] last, input logic [3:0] ld, input logic [3:0] st,
                      input logic [3:0] br, input logic [5:0] old, input logic [3:0] ldp,
                      input logic [3:0] stp, input logic [2:0] brp, input logic [31:0] cnt);
    exp_t e;
    e.last = last; e.ld = ld; e.st = st; e.br = br; e.old = old;
    e.ldp = ldp; e.stp = stp; e.brp = brp; e.cnt = cnt;
    cq.push_back(e);
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst) prev_v = 1'b0;
    else begin
      if (commit_valid) begin
        if (cq.size() == 0) chk("unexpected_commit", 32'(last_valid_commit_idx) + 1, 0);
        else begin
          m_e = cq.pop_front();
          chk("last_idx", 32'(last_valid_commit_idx), 32'(m_e.last));
          chk("load_valid", 32'(load_valid), 32'(m_e.ld));
          chk("store_valid", 32'(store_valid), 32'(m_e.st));
          chk("branch_valid", 32'(branch_valid), 32'(m_e.br));
          chk("oldest", 32'(oldest_inst_pointer), 32'(m_e.old));
          chk("load_ptr", 32'(load_commit_pointer), 32'(m_e.ldp));
          chk("store_ptr", 32'(store_commit_pointer), 32'(m_e.stp));
          chk("branch_ptr", 32'(branch_read_pointer), 32'(m_e.brp));
          chk("retired", retired_count, m_e.cnt);
        end
      end
      if (st_req_valid && !prev_v) begin
        if (sq.size() == 0) chk("unexpected_st_req", 32'(st_req_index) + 1, 0);
        else begin
          m_idx = sq.pop_front();
          chk("st_req_index", 32'(st_req_index), 32'(m_idx));
        end
      end else if (st_req_valid) chk("st_req_hold", 32'(st_req_index), 32'(m_idx));
      prev_v = st_req_valid;
    end
  end
  initial begin
    rst = 1; branch_miss = 0; st_req_ready = 0;
    rdy = '0; avail = '1; ild = '0; ist = '0; ibr = '0;
    cyc(2);
    rst = 0;
    #1;
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_oldest", 32'(oldest_inst_pointer), 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_st_req_valid", 32'(st_req_valid), 0);
    // four ready entries, load at 1, branch at 2
    avail[3:0] = '0; rdy[3:0] = '1; ild[1] = 1; ibr[2] = 1;
    push(3, 4'b0010, 0, 4'b0100, 0, 0, 0, 0, 0);
    cyc;
    avail[3:0] = '1; ild = '0; ibr = '0;
    #1;
    chk("t1_oldest", 32'(oldest_inst_pointer), 4);
    chk("t1_load_ptr", 32'(load_commit_pointer), 1);
    chk("t1_branch_ptr", 32'(branch_read_pointer), 1);
    chk("t1_retired", retired_count, 4);
    // hole at entry 6 stops the window
    avail[7:4] = '0; rdy[5:4] = 2'b11; rdy[6] = 0; rdy[7] = 1;
    push(1, 0, 0, 0, 4, 1, 0, 1, 4);
    cyc;
    avail[5:4] = 2'b11;
    #1;
    chk("t2_oldest", 32'(oldest_inst_pointer), 6);
    chk("t2_blocked", 32'(commit_valid), 0);
    cyc;
    // stores at 7 and 8; drain stalls three cycles
    avail[9:6] = '0; rdy[9:6] = '1; ist[7] = 1; ist[8] = 1;
    push(1, 0, 4'b0010, 0, 6, 1, 0, 1, 6); sq.push_back(0);
    cyc;
    avail[7:6] = 2'b11;
    #1;
    chk("t3_store_blocked", 32'(commit_valid), 0);
    chk("t3_st_req_valid", 32'(st_req_valid), 1);
    cyc(3);
    chk("t3_still_blocked", 32'(commit_valid), 0);
    st_req_ready = 1;
    cyc;
    st_req_ready = 0;
    push(1, 0, 4'b0001, 0, 8, 1, 1, 1, 8); sq.push_back(1);
    cyc;
    avail[9:8] = 2'b11; ist = '0; st_req_ready = 1;
    cyc;
    st_req_ready = 0;
    #1;
    chk("t3_oldest", 32'(oldest_inst_pointer), 10);
    chk("t3_store_ptr", 32'(store_commit_pointer), 2);
    chk("t3_retired", retired_count, 10);
    chk("t3_drain_idle", 32'(st_req_valid), 0);
    // walk head to 62 and store pointer to 15, one store per two cycles
    avail = '0; rdy = '1; st_req_ready = 1;
    for (int k = 0; k < 13; k++) begin
      ist = '0; ist[10 + 4 * k] = 1;
      push(3, 0, 4'b0001, 0, 6'(10 + 4 * k), 1, 4'(2 + k), 1, 32'(10 + 4 * k));
      sq.push_back(4'(2 + k));
      cyc;
      ist[14 + 4 * k] = 1;
      cyc;
    end
    // window wraps 62,63,0,1; store pointer wraps 15->0
    st_req_ready = 0; ist = '0; ist[63] = 1; ild[0] = 1; ibr[1] = 1;
    push(3, 4'b0100, 4'b0010, 4'b1000, 62, 1, 15, 1, 62); sq.push_back(15);
    cyc;
    avail = '1; ist = '0; ild = '0; ibr = '0;
    #1;
    chk("t4_oldest_wrap", 32'(oldest_inst_pointer), 2);
    chk("t4_store_ptr_wrap", 32'(store_commit_pointer), 0);
    chk("t4_load_ptr", 32'(load_commit_pointer), 2);
    chk("t4_branch_ptr", 32'(branch_read_pointer), 2);
    chk("t4_retired", retired_count, 66);
    chk("t4_st_req_valid", 32'(st_req_valid), 1);
    // misprediction suppresses retirement but not the in-flight write
    avail[4:2] = '0; branch_miss = 1;
    #1;
    chk("t5_miss_commit", 32'(commit_valid), 0);
    cyc;
    st_req_ready = 1;
    cyc;
    st_req_ready = 0;
    #1;
    chk("t5_write_done", 32'(st_req_valid), 0);
    chk("t5_oldest_hold", 32'(oldest_inst_pointer), 2);
    chk("t5_retired_hold", retired_count, 66);
    branch_miss = 0;
    push(2, 0, 0, 0, 2, 2, 0, 2, 66);
    cyc;
    avail[4:2] = '1;
    #1;
    chk("t5_oldest", 32'(oldest_inst_pointer), 5);
    chk("t5_retired", retired_count, 69);
    // reset while a write is pending
    avail[5] = 0; ist[5] = 1;
    push(0, 0, 4'b0001, 0, 5, 2, 0, 2, 69); sq.push_back(0);
    cyc;
    avail[5] = 1; ist = '0;
    cyc;
    chk("t6_pending", 32'(st_req_valid), 1);
    rst = 1; avail[3:0] = '0;
    #1;
    chk("t6_rst_commit", 32'(commit_valid), 0);
    cyc;
    chk("t6_st_req_valid", 32'(st_req_valid), 0);
    chk("t6_oldest", 32'(oldest_inst_pointer), 0);
    chk("t6_store_ptr", 32'(store_commit_pointer), 0);
    chk("t6_load_ptr", 32'(load_commit_pointer), 0);
    chk("t6_retired", retired_count, 0);
    rst = 0; avail = '1;
    cyc(2);
    chk("commit_queue_drained", 32'(cq.size()), 0);
    chk("store_queue_drained", 32'(sq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
